spi_master_cfg: RTL and testbench

Parametrised SPI master for the laser projector control path, successor to the fixed single-mode SPI I/O block. Adds a run-time programmable transfer length of 1..DATA_W bits, all four CPOL/CPHA modes and MSB/LSB-first ordering. It also adds per-transfer chip-select selection with frame hold, internal loopback, and overrun detection. It sits between the register/command logic and the external DAC/galvo SPI pins.

---
 rtl/spi_master_cfg.sv | 278 +++++++++++++++++++++++++++
 tb/tb_spi_master_cfg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cfg.sv
// -----------------------------------------------------------------------------
// spi_master_cfg
// Run-time configurable SPI master for the laser projector control path.
// Each transfer carries its own length (1..DATA_W bits), CPOL/CPHA mode,
// bit order, chip-select choice with optional frame hold, and an internal
// loopback. A start request that arrives while a transfer is in flight is
// dropped and flagged as an overrun.
//
// Ports
//   clk         system clock, all logic on its rising edge
//   rst         asynchronous active-high reset
//   start       one-cycle request; captures ctrl_reg and din when accepted
//   ctrl_reg    transfer configuration:
//                 [7:0] LEN, [15:8] DIV, [16] CPOL, [17] CPHA,
//                 [18] LSB_FIRST, [23:20] CS_SEL, [24] CS_HOLD, [25] LOOPBACK
//   din         transmit word (bits [LEN-1:0] are sent)
//   dout        received word, right-aligned, upper bits zero
//   status_reg  [0] busy, [1] done (sticky), [2] overrun (sticky)
//   sclk        SPI clock
//   mosi        SPI data out
//   miso        SPI data in
//   cs_n        active-low chip selects
// -----------------------------------------------------------------------------
module spi_master_cfg #(
   parameter int DATA_W = 32,
   parameter int NUM_CS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       ctrl_reg,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [31:0]       status_reg,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);

   localparam logic [7:0] DATA_W_8 = 8'(DATA_W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_XFER  = 2'd2,
      ST_TRAIL = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;

   // configuration captured at acceptance
   logic [7:0]        len_r;
   logic [7:0]        div_r;
   logic              cpha_r;
   logic              lsb_r;
   logic              hold_r;
   logic              lb_r;

   // timing and data path
   logic [7:0]        div_cnt_r;
   logic [7:0]        tog_cnt_r;
   logic [DATA_W-1:0] tx_sh_r;
   logic [DATA_W-1:0] rx_sh_r;
   logic [DATA_W-1:0] dout_r;
   logic              busy_r;
   logic              done_r;
   logic              overrun_r;
   logic              sclk_r;
   logic              mosi_r;
   logic [NUM_CS-1:0] cs_n_r;

   // decode of the incoming request
   logic [7:0]        len_field_s;
   logic [7:0]        len_eff_s;
   logic [DATA_W-1:0] tx_load_s;
   logic [NUM_CS-1:0] cs_sel_n_s;
   logic              unused_ctrl_s;

   // per-cycle control strobes
   logic              accept_s;
   logic              overrun_evt_s;
   logic              tick_s;
   logic              toggle_s;
   logic              last_tog_s;
   logic              odd_tog_s;
   logic              sample_s;
   logic              shift_s;
   logic              finish_s;
   logic              rx_bit_s;
   logic [7:0]        last_tog_idx_s;

   // Bit about to leave the transmit shifter for the chosen order.
   function automatic logic tx_head(input logic [DATA_W-1:0] sh, input logic lsb);
      return lsb ? sh[0] : sh[DATA_W-1];
   endfunction

   // Transmit shifter advanced by one bit toward its output end.
   function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] sh, input logic lsb);
      return lsb ? {1'b0, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], 1'b0};
   endfunction

   // Receive shifter with one new bit inserted. LSB-first bits enter at the
   // top and are right-aligned when the word is delivered.
   function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] sh, input logic lsb,
                                                  input logic b);
      return lsb ? {b, sh[DATA_W-1:1]} : {sh[DATA_W-2:0], b};
   endfunction

   assign unused_ctrl_s = ^{ctrl_reg[31:26], ctrl_reg[19]};

   // Decode length, pre-align transmit word and build the select pattern.
   always_comb begin
      len_field_s = ctrl_reg[7:0];
      if ((len_field_s == 8'd0) || (len_field_s > DATA_W_8)) begin
         len_eff_s = DATA_W_8;
      end else begin
         len_eff_s = len_field_s;
      end
      // MSB-first: move din[LEN-1] to the top so the shifter always leaves at one end
      if (ctrl_reg[18]) begin
         tx_load_s = din;
      end else begin
         tx_load_s = din << (DATA_W_8 - len_eff_s);
      end
      cs_sel_n_s = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (ctrl_reg[23:20] == 4'(i)) begin
            cs_sel_n_s[i] = 1'b0;
         end else begin
            cs_sel_n_s[i] = 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_nxt_s = ST_SETUP;
            else          state_nxt_s = ST_IDLE;
         end
         ST_SETUP: begin
            if (tick_s) state_nxt_s = ST_XFER;
            else        state_nxt_s = ST_SETUP;
         end
         ST_XFER: begin
            if (toggle_s && last_tog_s) state_nxt_s = ST_TRAIL;
            else                        state_nxt_s = ST_XFER;
         end
         ST_TRAIL: begin
            if (tick_s) state_nxt_s = ST_IDLE;
            else        state_nxt_s = ST_TRAIL;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output strobes: half-period ticks, sclk toggles, sample/shift events.
   always_comb begin
      accept_s       = start && (state_r == ST_IDLE);
      overrun_evt_s  = start && (state_r != ST_IDLE);
      tick_s         = (state_r != ST_IDLE) && (div_cnt_r == div_r);
      // the SETUP tick is toggle 1, so toggles happen in SETUP and XFER
      toggle_s       = tick_s && ((state_r == ST_SETUP) || (state_r == ST_XFER));
      last_tog_idx_s = {len_r[6:0], 1'b0} - 8'd1;
      last_tog_s     = (tog_cnt_r == last_tog_idx_s);
      // tog_cnt_r holds toggles already made, so an even count means an odd toggle
      odd_tog_s      = ~tog_cnt_r[0];
      if (cpha_r) begin
         sample_s = toggle_s && !odd_tog_s;
         shift_s  = toggle_s && odd_tog_s;
      end else begin
         sample_s = toggle_s && odd_tog_s;
         shift_s  = toggle_s && !odd_tog_s && !last_tog_s;
      end
      finish_s       = tick_s && (state_r == ST_TRAIL);
      rx_bit_s       = lb_r ? mosi_r : miso;
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_r     <= 8'd0;
         div_r     <= 8'd0;
         cpha_r    <= 1'b0;
         lsb_r     <= 1'b0;
         hold_r    <= 1'b0;
         lb_r      <= 1'b0;
         div_cnt_r <= 8'd0;
         tog_cnt_r <= 8'd0;
         tx_sh_r   <= '0;
         rx_sh_r   <= '0;
         dout_r    <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         overrun_r <= 1'b0;
         sclk_r    <= 1'b0;
         mosi_r    <= 1'b0;
         cs_n_r    <= '1;
      end else begin
         if (accept_s) begin
            len_r     <= len_eff_s;
            div_r     <= ctrl_reg[15:8];
            cpha_r    <= ctrl_reg[17];
            lsb_r     <= ctrl_reg[18];
            hold_r    <= ctrl_reg[24];
            lb_r      <= ctrl_reg[25];
            div_cnt_r <= 8'd0;
            tog_cnt_r <= 8'd0;
            rx_sh_r   <= '0;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
            sclk_r    <= ctrl_reg[16];
            cs_n_r    <= cs_sel_n_s;
            if (ctrl_reg[17]) begin
               tx_sh_r <= tx_load_s;
               mosi_r  <= 1'b0;
            end else begin
               tx_sh_r <= tx_shift(tx_load_s, ctrl_reg[18]);
               mosi_r  <= tx_head(tx_load_s, ctrl_reg[18]);
            end
         end else begin
            if (overrun_evt_s) begin
               overrun_r <= 1'b1;
            end
            if (tick_s) begin
               div_cnt_r <= 8'd0;
            end else if (state_r != ST_IDLE) begin
               div_cnt_r <= div_cnt_r + 8'd1;
            end
            if (toggle_s) begin
               tog_cnt_r <= tog_cnt_r + 8'd1;
               sclk_r    <= ~sclk_r;
            end
            if (shift_s) begin
               mosi_r  <= tx_head(tx_sh_r, lsb_r);
               tx_sh_r <= tx_shift(tx_sh_r, lsb_r);
            end
            if (sample_s) begin
               rx_sh_r <= rx_shift(rx_sh_r, lsb_r, rx_bit_s);
            end
            if (finish_s) begin
               if (lsb_r) begin
                  dout_r <= rx_sh_r >> (DATA_W_8 - len_r);
               end else begin
                  dout_r <= rx_sh_r;
               end
               busy_r <= 1'b0;
               done_r <= 1'b1;
               mosi_r <= 1'b0;
               if (!hold_r) begin
                  cs_n_r <= '1;
               end
            end
         end
      end
   end

   assign dout       = dout_r;
   assign status_reg = {29'd0, overrun_r, done_r, busy_r};
   assign sclk       = sclk_r;
   assign mosi       = mosi_r;
   assign cs_n       = cs_n_r;

endmodule

// File: tb/tb_spi_master_cfg.sv
// -----------------------------------------------------------------------------
// Self-checking bench for spi_master_cfg: directed scenarios plus randomized
// transfers, judged against a word-level model of what each transfer must do.
// -----------------------------------------------------------------------------
module tb_spi_master_cfg;

   localparam int DATA_W = 32;
   localparam int NUM_CS = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [31:0]       ctrl_reg;
   logic [DATA_W-1:0] din;
   logic [DATA_W-1:0] dout;
   logic [31:0]       status_reg;
   logic              sclk;
   logic              mosi;
   logic              miso;
   logic              miso_drv;
   logic              miso_dly;
   logic              use_dly;
   logic [NUM_CS-1:0] cs_n;
   logic [NUM_CS-1:0] cs_idle_exp;

   int n_checks = 0;
   int n_pass   = 0;

   assign #1 miso_dly = mosi;
   assign miso = use_dly ? miso_dly : miso_drv;

   always #5 clk = ~clk;

   spi_master_cfg #(.DATA_W(DATA_W), .NUM_CS(NUM_CS)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .ctrl_reg   (ctrl_reg),
      .din        (din),
      .dout       (dout),
      .status_reg (status_reg),
      .sclk       (sclk),
      .mosi       (mosi),
      .miso       (miso),
      .cs_n       (cs_n)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // position of the i-th transmitted bit within the word
   function automatic int bitpos(input int i, input int len, input bit lsb);
      return lsb ? i : (len - 1 - i);
   endfunction

   // One transfer. slv is the slave's word (used when neither loopback nor the
   // delayed-mosi path is selected); intr_c > 0 pulses start that many cycles
   // after acceptance, with garbage on ctrl_reg/din.
   task automatic run_xfer(input string name, input logic [31:0] ctrl, input logic [DATA_W-1:0] tx,
                           input logic [DATA_W-1:0] slv, input bit dly, input int intr_c);
      int len, h, sel, busy_len, c, togs, first_c, last_c, cs_bad, bi, nb;
      bit cpol, cpha, lsb, hold, lb, ovr;
      logic [DATA_W-1:0] ones, mask, mosi_word, exp_dout;
      logic [NUM_CS-1:0] exp_cs, exp_after;
      logic prev_sclk;

      len = int'(ctrl[7:0]);
      if (len == 0 || len > DATA_W) len = DATA_W;
      h    = int'(ctrl[15:8]) + 1;
      cpol = ctrl[16];
      cpha = ctrl[17];
      lsb  = ctrl[18];
      sel  = int'(ctrl[23:20]);
      hold = ctrl[24];
      lb   = ctrl[25];
      ones = '1;
      mask = ones >> (DATA_W - len);
      busy_len = (2 * len + 1) * h;
      exp_cs = '1;
      if (sel < NUM_CS) exp_cs[sel] = 1'b0;
      exp_after = (hold && sel < NUM_CS) ? exp_cs : {NUM_CS{1'b1}};
      exp_dout  = (lb || dly) ? (tx & mask) : (slv & mask);
      ovr = (intr_c >= 1) && (intr_c <= busy_len - 1);

      check_val({name, " idle cs_n"}, 64'(cs_n), 64'(cs_idle_exp));

      @(negedge clk);
      ctrl_reg = ctrl;
      din      = tx;
      use_dly  = dly;
      start    = 1'b1;
      if (!lb && !cpha) miso_drv = slv[bitpos(0, len, lsb)];
      else              miso_drv = 1'($urandom);
      @(posedge clk);
      #1;
      start = 1'b0;
      check_val({name, " status at accept"}, 64'(status_reg), 64'h1);
      check_val({name, " sclk at accept"}, 64'(sclk), 64'(cpol));
      check_val({name, " cs_n at accept"}, 64'(cs_n), 64'(exp_cs));
      if (!cpha) check_val({name, " first mosi"}, 64'(mosi), 64'(tx[bitpos(0, len, lsb)]));

      prev_sclk = sclk;
      togs = 0; first_c = -1; last_c = -1; cs_bad = 0; c = 0;
      mosi_word = '0;
      while (status_reg[0] === 1'b1 && c < busy_len + 8) begin
         @(posedge clk);
         #1;
         c++;
         start = (c == intr_c);
         if (c == intr_c) begin
            ctrl_reg = $urandom;
            din      = DATA_W'($urandom);
         end
         if (status_reg[0] === 1'b1 && cs_n !== exp_cs) cs_bad++;
         if (sclk !== prev_sclk) begin
            togs++;
            prev_sclk = sclk;
            if (togs == 1) first_c = c;
            last_c = c;
            bi = (togs - 1) / 2;
            if (((togs % 2) == 1) != cpha) begin
               if (bi < len) mosi_word[bitpos(bi, len, lsb)] = mosi;
            end else if (!lb && togs < 2 * len) begin
               nb = cpha ? bi : togs / 2;
               if (nb < len) miso_drv = slv[bitpos(nb, len, lsb)];
            end
         end
      end
      start = 1'b0;

      check_val({name, " busy cycles"}, 64'(c), 64'(busy_len));
      check_val({name, " toggle count"}, 64'(togs), 64'(2 * len));
      check_val({name, " first toggle"}, 64'(first_c), 64'(h));
      check_val({name, " last toggle"}, 64'(last_c), 64'(2 * len * h));
      check_val({name, " cs_n during busy"}, 64'(cs_bad), 64'd0);
      check_val({name, " mosi word"}, 64'(mosi_word), 64'(tx & mask));
      check_val({name, " dout"}, 64'(dout), 64'(exp_dout));
      check_val({name, " status at end"}, 64'(status_reg), ovr ? 64'h6 : 64'h2);
      check_val({name, " mosi at end"}, 64'(mosi), 64'd0);
      check_val({name, " sclk idle"}, 64'(sclk), 64'(cpol));
      check_val({name, " cs_n at end"}, 64'(cs_n), 64'(exp_after));
      cs_idle_exp = exp_after;
   endtask

   initial begin
      logic [31:0] ctrl;
      int togs, c;
      logic prev;

      rst = 1'b1; start = 1'b0; ctrl_reg = 32'd0; din = '0;
      miso_drv = 1'b0; use_dly = 1'b0; cs_idle_exp = '1;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset dout", 64'(dout), 64'd0);
      check_val("reset status", 64'(status_reg), 64'd0);
      check_val("reset sclk", 64'(sclk), 64'd0);
      check_val("reset mosi", 64'(mosi), 64'd0);
      check_val("reset cs_n", 64'(cs_n), 64'hF);
      @(negedge clk);
      rst = 1'b0;

      // mode 0, LEN 8, DIV 0, loopback, 0xA5
      run_xfer("m0_a5", 32'h0200_0008, 32'h0000_00A5, 32'h0, 1'b0, 0);
      // mode 3, LEN 32, DIV 2, MSB first, miso = mosi delayed 1 ns
      run_xfer("m3_dly", 32'h0003_0220, 32'hFF00_FFAA, 32'h0, 1'b1, 0);
      // LSB first, LEN 4, CPHA 1, loopback
      run_xfer("lsb4", 32'h0206_0004, 32'h0000_0001, 32'h0, 1'b0, 0);
      // slave-driven word in each mode
      run_xfer("slv_m0", 32'h0010_0110, 32'h0000_3C5A, 32'h0000_96E1, 1'b0, 0);
      run_xfer("slv_m1", 32'h0022_000C, 32'h0000_0ABC, 32'h0000_0F0F, 1'b0, 0);
      run_xfer("slv_m2", 32'h0005_0107, 32'h0000_0055, 32'h0000_0049, 1'b0, 0);
      // frame hold on select 2 across three transfers
      run_xfer("hold1", 32'h0120_0108, 32'h0000_0011, 32'h0000_00C3, 1'b0, 0);
      run_xfer("hold2", 32'h0120_0108, 32'h0000_0022, 32'h0000_003C, 1'b0, 0);
      run_xfer("hold3", 32'h0020_0108, 32'h0000_0033, 32'h0000_0081, 1'b0, 0);
      // hold then switch to another select
      run_xfer("hold_a", 32'h0110_0006, 32'h0000_0015, 32'h0000_002A, 1'b0, 0);
      run_xfer("switch", 32'h0030_0006, 32'h0000_002A, 32'h0000_0015, 1'b0, 0);
      // start pulsed mid-transfer, and in the cycle busy falls
      run_xfer("ovr_mid", 32'h0200_0008, 32'h0000_005A, 32'h0, 1'b0, 6);
      run_xfer("after_ovr", 32'h0200_0008, 32'h0000_00C7, 32'h0, 1'b0, 0);
      run_xfer("ovr_edge", 32'h0200_0008, 32'h0000_0096, 32'h0, 1'b0, 16);
      // LEN 0 and out-of-range LEN select the full width; CS_SEL beyond NUM_CS
      run_xfer("len0", 32'h0200_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
      run_xfer("len_big", 32'h0074_0028, 32'h1234_5678, 32'h8765_4321, 1'b0, 0);

      // reset at toggle 5 of a LEN 16 transfer
      @(negedge clk);
      ctrl_reg = 32'h0001_0110;
      din      = 32'h0000_FFFF;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      prev = sclk; togs = 0; c = 0;
      while (togs < 5 && c < 200) begin
         @(posedge clk);
         #1;
         c++;
         if (sclk !== prev) begin
            togs++;
            prev = sclk;
         end
      end
      check_val("rst reached toggle 5", 64'(togs), 64'd5);
      check_val("rst cs_n before", 64'(cs_n), 64'hE);
      #2;
      rst = 1'b1;
      #1;
      check_val("rst async status", 64'(status_reg), 64'd0);
      check_val("rst async dout", 64'(dout), 64'd0);
      check_val("rst async sclk", 64'(sclk), 64'd0);
      check_val("rst async mosi", 64'(mosi), 64'd0);
      check_val("rst async cs_n", 64'(cs_n), 64'hF);
      @(negedge clk);
      rst = 1'b0;
      cs_idle_exp = '1;
      run_xfer("post_rst", 32'h0000_0110, 32'h0000_ABCD, 32'h0000_1357, 1'b0, 0);

      // randomized transfers
      for (int n = 0; n < 40; n++) begin
         int len_e, blen, ic;
         bit dly;
         ctrl = $urandom;
         ctrl[7:0]   = 8'($urandom_range(0, 40));
         ctrl[15:8]  = 8'($urandom_range(0, 3));
         ctrl[23:20] = 4'($urandom_range(0, 5));
         len_e = int'(ctrl[7:0]);
         if (len_e == 0 || len_e > DATA_W) len_e = DATA_W;
         blen = (2 * len_e + 1) * (int'(ctrl[15:8]) + 1);
         ic   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, blen - 1)) : 0;
         dly  = ($urandom_range(0, 3) == 0);
         run_xfer($sformatf("rnd%0d", n), ctrl, DATA_W'($urandom), DATA_W'($urandom), dly, ic);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
